// File: rtl/prime_buffer.sv
// Buffers primes reported by the prime-search engine and keeps running statistics on them.
// Latency: a hit appears on OutValid/OutPrime one cycle after its edge; statistics update on that same edge.
// Backpressure: OutReady stalls the FIFO; a hit arriving while full with no pop is dropped and sets sticky Overflow.
module prime_buffer #(
    parameter int NUMW  = 10,
    parameter int DEPTH = 16,
    parameter int CNTW  = 8
) (
    input  logic                       SysClk,
    input  logic                       Reset,
    input  logic                       NumValid,
    input  logic                       Prime,
    input  logic [NUMW-1:0]            NumberChecked,
    input  logic                       Clear,
    input  logic                       OutReady,
    output logic                       OutValid,
    output logic [NUMW-1:0]            OutPrime,
    output logic [$clog2(DEPTH+1)-1:0] Level,
    output logic                       Overflow,
    output logic [CNTW-1:0]            PrimeCount,
    output logic [CNTW-1:0]            TwinCount,
    output logic [NUMW-1:0]            LastPrime,
    output logic [NUMW-1:0]            MaxGap
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [NUMW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   lvl;
    logic            have_prev;
    logic            hit, pop, push, drop, full;
    logic [NUMW-1:0] gap;

    assign hit  = NumValid & Prime;
    assign full = (lvl == LW'(DEPTH));
    assign pop  = OutValid & OutReady;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = hit & (~full | pop);
    assign drop = hit & full & ~pop;
    assign gap  = NumberChecked - LastPrime;

    assign OutValid = (lvl != '0);
    assign OutPrime = OutValid ? mem[rd_ptr] : '0;
    assign Level    = lvl;

    always_ff @(posedge SysClk) begin
        if (push && !Clear)
            mem[wr_ptr] <= NumberChecked;
    end

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lvl        <= '0;
            Overflow   <= 1'b0;
            PrimeCount <= '0;
            TwinCount  <= '0;
            LastPrime  <= '0;
            MaxGap     <= '0;
            have_prev  <= 1'b0;
        end else if (Clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lvl        <= '0;
            Overflow   <= 1'b0;
            PrimeCount <= '0;
            TwinCount  <= '0;
            LastPrime  <= '0;
            MaxGap     <= '0;
            have_prev  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                lvl <= lvl + 1'b1;
            else if (pop && !push)
                lvl <= lvl - 1'b1;
            if (drop)
                Overflow <= 1'b1;
            // Statistics see every hit, including ones the FIFO had to drop.
            if (hit) begin
                if (PrimeCount != '1)
                    PrimeCount <= PrimeCount + 1'b1;
                if (have_prev) begin
                    if (gap > MaxGap)
                        MaxGap <= gap;
                    if (gap == NUMW'(2) && TwinCount != '1)
                        TwinCount <= TwinCount + 1'b1;
                end
                have_prev <= 1'b1;
                LastPrime <= NumberChecked;
            end
        end
    end

endmodule

// File: tb/tb_prime_buffer.sv
// Directed bench for prime_buffer (DEPTH=4): stimulus queues expected primes, a negedge monitor checks each pop.
module tb_prime_buffer;

    localparam int NUMW  = 10;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;

    logic            SysClk = 1'b0;
    logic            Reset;
    logic            NumValid, Prime, Clear, OutReady;
    logic [NUMW-1:0] NumberChecked;
    logic            OutValid, Overflow;
    logic [NUMW-1:0] OutPrime, LastPrime, MaxGap;
    logic [$clog2(DEPTH+1)-1:0] Level;
    logic [CNTW-1:0] PrimeCount, TwinCount;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q [$];

    prime_buffer #(.NUMW(NUMW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .SysClk(SysClk), .Reset(Reset), .NumValid(NumValid), .Prime(Prime),
        .NumberChecked(NumberChecked), .Clear(Clear), .OutReady(OutReady),
        .OutValid(OutValid), .OutPrime(OutPrime), .Level(Level), .Overflow(Overflow),
        .PrimeCount(PrimeCount), .TwinCount(TwinCount), .LastPrime(LastPrime), .MaxGap(MaxGap)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the head of the expected queue.
    always @(negedge SysClk) begin
        if (Reset && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0d, expected nothing", OutPrime);
            end else begin
                chk("out_prime", int'(OutPrime), exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic nv, input logic pr, input int n, input logic rdy, input logic clr);
        logic [31:0] nn;
        nn            = n;
        NumValid      = nv;
        Prime         = pr;
        NumberChecked = nn[NUMW-1:0];
        OutReady      = rdy;
        Clear         = clr;
        @(posedge SysClk);
        #1;
        NumValid = 1'b0;
        Prime    = 1'b0;
        Clear    = 1'b0;
    endtask

    task automatic hit(input int n, input logic store);
        if (store) exp_q.push_back(n);
        cyc(1'b1, 1'b1, n, OutReady, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 0, OutReady, 1'b0);
    endtask

    task automatic do_clear();
        cyc(1'b0, 1'b0, 0, OutReady, 1'b1);
        exp_q.delete();
    endtask

    task automatic drain(input string nm);
        OutReady = 1'b1;
        idle(DEPTH + 2);
        chk({nm, "_level"}, int'(Level), 0);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        Reset = 1'b0; NumValid = 1'b0; Prime = 1'b0; Clear = 1'b0;
        OutReady = 1'b0; NumberChecked = '0;

        // Reset held with strobes pulsing: everything must stay zero.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2 + i, 1'b0, 1'b0);
        chk("rst_outvalid", int'(OutValid), 0);
        chk("rst_outprime", int'(OutPrime), 0);
        chk("rst_level", int'(Level), 0);
        chk("rst_overflow", int'(Overflow), 0);
        chk("rst_primecount", int'(PrimeCount), 0);
        chk("rst_twincount", int'(TwinCount), 0);
        chk("rst_lastprime", int'(LastPrime), 0);
        chk("rst_maxgap", int'(MaxGap), 0);
        Reset = 1'b1;
        idle(1);

        // First hit appears one cycle after its edge.
        hit(2, 1'b1);
        chk("lat_outvalid", int'(OutValid), 1);
        chk("lat_outprime", int'(OutPrime), 2);
        drain("lat");

        // Streaming with OutReady high.
        do_clear();
        OutReady = 1'b1;
        for (int n = 2; n <= 13; n++) begin
            if (n == 2 || n == 3 || n == 5 || n == 7 || n == 11 || n == 13) hit(n, 1'b1);
            else cyc(1'b1, 1'b0, n, 1'b1, 1'b0);
        end
        idle(3);
        chk("stream_primecount", int'(PrimeCount), 6);
        chk("stream_twincount", int'(TwinCount), 3);
        chk("stream_maxgap", int'(MaxGap), 4);
        chk("stream_lastprime", int'(LastPrime), 13);
        chk("stream_overflow", int'(Overflow), 0);
        chk("stream_queue_left", exp_q.size(), 0);

        // Overflow: fifth prime is dropped but still counted.
        OutReady = 1'b0;
        do_clear();
        hit(2, 1'b1); hit(3, 1'b1); hit(5, 1'b1); hit(7, 1'b1); hit(11, 1'b0);
        chk("ovf_level", int'(Level), 4);
        chk("ovf_overflow", int'(Overflow), 1);
        chk("ovf_primecount", int'(PrimeCount), 5);
        chk("ovf_lastprime", int'(LastPrime), 11);
        drain("ovf");
        chk("ovf_sticky", int'(Overflow), 1);

        // Full FIFO with simultaneous push and pop.
        OutReady = 1'b0;
        do_clear();
        hit(2, 1'b1); hit(3, 1'b1); hit(5, 1'b1); hit(7, 1'b1);
        exp_q.push_back(13);
        cyc(1'b1, 1'b1, 13, 1'b1, 1'b0);
        OutReady = 1'b0;
        chk("full_pp_level", int'(Level), 4);
        chk("full_pp_overflow", int'(Overflow), 0);
        drain("full_pp");

        // Asynchronous reset mid-stream.
        OutReady = 1'b0;
        do_clear();
        hit(2, 1'b1); hit(3, 1'b1); hit(5, 1'b1);
        Reset = 1'b0;
        exp_q.delete();
        #2;
        chk("async_rst_level", int'(Level), 0);
        idle(1);
        Reset = 1'b1;
        idle(1);
        hit(7, 1'b1); hit(11, 1'b1);
        chk("mid_rst_primecount", int'(PrimeCount), 2);
        chk("mid_rst_twincount", int'(TwinCount), 0);
        chk("mid_rst_maxgap", int'(MaxGap), 4);
        chk("mid_rst_level", int'(Level), 2);
        drain("mid_rst");

        // Clear wins over a simultaneous hit and pop.
        OutReady = 1'b0;
        do_clear();
        hit(2, 1'b1); hit(3, 1'b1);
        cyc(1'b1, 1'b1, 5, 1'b1, 1'b1);
        exp_q.delete();
        OutReady = 1'b0;
        chk("clr_outvalid", int'(OutValid), 0);
        chk("clr_level", int'(Level), 0);
        chk("clr_primecount", int'(PrimeCount), 0);
        chk("clr_twincount", int'(TwinCount), 0);
        chk("clr_lastprime", int'(LastPrime), 0);
        chk("clr_maxgap", int'(MaxGap), 0);
        hit(7, 1'b1);
        chk("post_clr_primecount", int'(PrimeCount), 1);
        chk("post_clr_maxgap", int'(MaxGap), 0);
        drain("post_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prime_buffer.md
Name: prime_buffer

Overview:
- Downstream consumer of the prime-search engine (primenums).
- Captures every number the engine reports as prime into a FIFO and streams the primes out over a ready/valid interface.
- Keeps running statistics on the primes it sees: count, twin-prime pairs, last prime and largest gap between consecutive primes.
- Its output feeds the display/report stage.

Parameters:
- NUMW, 10: width of NumberChecked and of the stored primes; matches the engine's NumberChecked.
- DEPTH, 16: number of FIFO entries; power of two, at least 2.
- CNTW, 8: width of the statistics counters; matches the engine's NumberofPrimesFound.

Ports:
- SysClk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- NumValid  in  1  one-cycle strobe; Prime and NumberChecked are valid in this cycle.
- Prime  in  1  engine result for NumberChecked.
- NumberChecked  in  NUMW  number just tested by the engine.
- Clear  in  1  synchronous clear of FIFO and statistics.
- OutReady  in  1  consumer accepts OutPrime.
- OutValid  out  1  FIFO non-empty.
- OutPrime  out  NUMW  FIFO head value.
- Level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- Overflow  out  1  sticky; a prime was dropped because the FIFO was full.
- PrimeCount  out  CNTW  primes accepted into statistics; saturates at all-ones.
- TwinCount  out  CNTW  consecutive prime pairs differing by 2; saturates.
- LastPrime  out  NUMW  most recent prime seen.
- MaxGap  out  NUMW  largest difference between consecutive primes seen.

Behaviour:
- Reset low (any time, asynchronous): FIFO emptied (pointers 0, Level 0, OutValid 0). OutPrime, Overflow, PrimeCount, TwinCount, LastPrime, MaxGap all 0. Internal flag HavePrev cleared.
- Clear high at a clock edge: same effect as reset, applied synchronously. Clear has priority over push and pop in that cycle.
- Event "hit" = NumValid & Prime. NumValid with Prime=0 changes nothing.
- Push on a hit:
  - NumberChecked is written at the write pointer if the FIFO is not full.
  - If the FIFO is full and no pop happens in the same cycle, the value is dropped and Overflow is set to 1.
  - Overflow stays 1 until Reset or Clear.
- Pop: occurs when OutValid & OutReady at a clock edge; the read pointer advances.
  - OutPrime is always the head entry, read combinationally from the FIFO array.
  - OutPrime is don't-care when OutValid is 0; the bench must not check it then.
- Simultaneous push and pop:
  - When full: the pop frees a slot, the push is accepted, Level stays DEPTH, no overflow.
  - When empty: the pop cannot occur because OutValid is 0.
- Latency: a prime pushed into an empty FIFO appears on OutValid/OutPrime the cycle after the hit edge.
- Level: +1 on push only, −1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Statistics update on every hit, whether or not the value was stored in the FIFO:
  - PrimeCount += 1, saturating.
  - If HavePrev: gap = NumberChecked − LastPrime (NUMW-bit unsigned).
    - If gap > MaxGap, MaxGap takes gap.
    - If gap == 2, TwinCount += 1, saturating.
  - If not HavePrev: no gap or twin update; HavePrev is set.
  - LastPrime takes NumberChecked.
- Input ordering: the engine guarantees strictly increasing NumberChecked between Reset/Clear events. Non-increasing input is undefined.
- No combinational path from NumValid or Prime to any output.

Test Plan:
- Reset check: hold Reset low for 3 cycles with NumValid pulsing → every output reads 0. Release and the first hit on 2 gives OutValid=1 and OutPrime=2 one cycle later.
- Stream hits 2,3,5,7,11,13 (non-primes 4,6,8,9,10,12 strobed with Prime=0), OutReady=1 → outputs appear in order, each exactly once. PrimeCount=6, TwinCount=3, MaxGap=4, LastPrime=13, Overflow=0.
- DEPTH=4, OutReady=0, hits 2,3,5,7,11 → Level=4 and Overflow=1. Drain yields 2,3,5,7 only. PrimeCount=5 and LastPrime=11 (statistics still count the dropped prime).
- DEPTH=4 full, a hit on 13 in the same cycle as OutReady=1 → Level stays 4, Overflow stays 0, and the drain sequence ends with 13.
- Assert Reset mid-stream after hits 2,3,5, then resume with hits 7,11 → PrimeCount=2, TwinCount=0, MaxGap=4, and the FIFO holds only 7,11.
- Pulse Clear in the same cycle as a hit and a pop → all statistics 0 and the FIFO empty on the next cycle. The hit is discarded.
